// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: shadow nibble latch, prescaled scan, hex/decimal decode.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
    parameter int unsigned N_DIGITS   = 4,
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned ACTIVE_LOW = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic                    hex_mode,
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     an,
    output logic                    tick
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] PrescMax = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IdxMax   = IW'(N_DIGITS - 1);
    localparam logic [6:0]    SegOff   = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [N_DIGITS-1:0] AnOff = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [6:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  tick_q, tick_d;

    logic                  advance;
    logic                  blank;
    logic [3:0]            nibble;
    logic [6:0]            seg_l;
    logic [N_DIGITS-1:0]   an_l;

    function automatic logic [6:0] decode(input logic [3:0] nib, input logic hex);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        // Decimal mode shows the error dash for non-BCD nibbles.
        if (!hex && (nib > 4'h9)) begin
            s = 7'h40;
        end
        return s;
    endfunction

    always_comb begin
        shadow_d = load ? value : shadow_q;
        presc_d  = presc_q;
        idx_d    = idx_q;
        tick_d   = 1'b0;
        advance  = (presc_q == PrescMax);

        if (enable) begin
            if (advance) begin
                presc_d = '0;
                idx_d   = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        nibble = shadow_q[{idx_q, 2'b00} +: 4];
        blank  = 1'b0;
`ifdef SEG7_LZB_EN
        // Blank when this digit and every more-significant digit is zero; digit 0 always shows.
        if (idx_q != '0) begin
            blank = ((shadow_q >> {idx_q, 2'b00}) == '0);
        end
`else
        blank = 1'b0;
`endif

        seg_l = 7'h00;
        an_l  = '0;
        if (enable) begin
            seg_l = blank ? 7'h00 : decode(nibble, hex_mode);
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                an_l[i] = (idx_q == IW'(i));
            end
        end

        seg_d = (ACTIVE_LOW != 0) ? ~seg_l : seg_l;
        an_d  = (ACTIVE_LOW != 0) ? ~an_l : an_l;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_q <= '0;
            presc_q  <= '0;
            idx_q    <= '0;
            seg_q    <= SegOff;
            an_q     <= AnOff;
            tick_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            tick_q   <= tick_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (N_DIGITS=4, SCAN_DIV=3); expectations adapt to SEG7_LZB_EN.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic        hex_mode;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        tick;

`ifdef SEG7_LZB_EN
    localparam logic [6:0] Z = 7'h00;
`else
    localparam logic [6:0] Z = 7'h3F;
`endif

    logic [11:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_sample = 0;

    seg7_scan_driver #(
        .N_DIGITS  (4),
        .SCAN_DIV  (3),
        .ACTIVE_LOW(0)
    ) dut (
        .clock   (clk),
        .reset   (reset),
        .enable  (enable),
        .load    (load),
        .value   (value),
        .hex_mode(hex_mode),
        .seg     (seg),
        .an      (an),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    // Monitor: every queued expectation belongs to the current cycle's registered outputs.
    always @(negedge clk) begin
        logic [11:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({seg, an, tick} !== e) begin
                n_fail++;
                $display("FAIL sample %0d: got seg=%h an=%b tick=%b, expected seg=%h an=%b tick=%b",
                         n_sample, seg, an, tick, e[11:5], e[4:1], e[0]);
            end
            n_sample++;
        end
    end

    task automatic cyc(input logic [6:0] s, input logic [3:0] a, input logic t);
        @(posedge clk);
        #1;
        exp_q.push_back({s, a, t});
    endtask

    task automatic slot(input logic [6:0] s, input logic [3:0] a);
        cyc(s, a, 1'b0);
        cyc(s, a, 1'b0);
        cyc(s, a, 1'b1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; value = 16'h0; hex_mode = 1'b1;
        // Reset held two cycles
        cyc(7'h00, 4'b0000, 1'b0);
        cyc(7'h00, 4'b0000, 1'b0);

        // Load 1234 while disabled, then scan
        reset = 1'b0; load = 1'b1; value = 16'h1234;
        cyc(7'h00, 4'b0000, 1'b0);
        load = 1'b0; enable = 1'b1;
        slot(7'h66, 4'b0001);
        slot(7'h4F, 4'b0010);
        slot(7'h5B, 4'b0100);
        slot(7'h06, 4'b1000);
        slot(7'h66, 4'b0001);

        // 00AF hex mode; load edge still shows old shadow
        load = 1'b1; value = 16'h00AF;
        cyc(7'h4F, 4'b0010, 1'b0);
        load = 1'b0;
        cyc(7'h77, 4'b0010, 1'b0);
        cyc(7'h77, 4'b0010, 1'b1);
        slot(Z, 4'b0100);
        slot(Z, 4'b1000);
        slot(7'h71, 4'b0001);
        // Decimal mode: A and F become dashes
        hex_mode = 1'b0;
        slot(7'h40, 4'b0010);
        slot(Z, 4'b0100);
        slot(Z, 4'b1000);
        slot(7'h40, 4'b0001);
        hex_mode = 1'b1;
        slot(7'h77, 4'b0010);

        // Drop enable at presc=1, idx=2
        cyc(Z, 4'b0100, 1'b0);
        enable = 1'b0;
        repeat (5) cyc(7'h00, 4'b0000, 1'b0);
        enable = 1'b1;
        cyc(Z, 4'b0100, 1'b0);
        cyc(Z, 4'b0100, 1'b1);
        slot(Z, 4'b1000);

        // Load 9999 on the advance edge
        cyc(7'h71, 4'b0001, 1'b0);
        cyc(7'h71, 4'b0001, 1'b0);
        load = 1'b1; value = 16'h9999;
        cyc(7'h71, 4'b0001, 1'b1);
        load = 1'b0;
        cyc(7'h6F, 4'b0010, 1'b0);

        // Reset mid-slot with a coincident load: reset must win
        reset = 1'b1; load = 1'b1; value = 16'h1234;
        cyc(7'h00, 4'b0000, 1'b0);
        reset = 1'b0; load = 1'b0;
        slot(7'h3F, 4'b0001);
        slot(Z, 4'b0010);

        // 0050: upper two digits are leading zeros
        load = 1'b1; value = 16'h0050;
        cyc(Z, 4'b0100, 1'b0);
        load = 1'b0;
        cyc(Z, 4'b0100, 1'b0);
        cyc(Z, 4'b0100, 1'b1);
        slot(Z, 4'b1000);
        slot(7'h3F, 4'b0001);
        slot(7'h6D, 4'b0010);

        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
